// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule.
//
// Contents:
//   AES_NUM_ROUNDS  last round-key index for AES-128 (10)
//   AES_RCON_INIT   first round constant (8'h01)
//   ke_state_e      key-expander state encoding (IDLE, EMIT, SUB, COMPUTE)
//   rot_word()      cyclic left rotate of a 32-bit word by one byte
//   xtime()         multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
package aes_pkg;

    localparam int         AES_NUM_ROUNDS = 10;
    localparam logic [7:0] AES_RCON_INIT  = 8'h01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        SUB     = 2'd2,
        COMPUTE = 2'd3
    } ke_state_e;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_round_step.sv
// One AES-128 key-schedule round, purely combinational.
//
// Ports:
//   prevKey  [127:0]  previous round key, [127:96] is w0
//   subWord  [31:0]   SubWord(RotWord(w3)) of prevKey
//   rcon     [7:0]    round constant for this step
//   nextKey  [127:0]  following round key, [127:96] is the first word
module key_round_step (
    input  logic [127:0] prevKey,
    input  logic [31:0]  subWord,
    input  logic [7:0]   rcon,
    output logic [127:0] nextKey
);

    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    // Each new word chains off the one just produced, so the four XORs
    // form a ripple rather than four independent terms.
    always_comb begin
        t  = subWord ^ {rcon, 24'h0};
        n0 = prevKey[127:96] ^ t;
        n1 = prevKey[95:64]  ^ n0;
        n2 = prevKey[63:32]  ^ n1;
        n3 = prevKey[31:0]   ^ n2;
        nextKey = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/key_expander.sv
// Iterative AES-128 key schedule. Takes a cipher key on start and emits
// round keys 0..NUM_ROUNDS in order on a valid/ready stream. The S-box is
// external: this block drives the word to substitute and uses the reply.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, keyIn         new-schedule request (taken only while ready=1)
//   ready                idle, able to accept start
//   roundKey, roundKeyIndex, roundKeyValid, roundKeyReady
//                        round-key stream; a key transfers on the cycle
//                        where roundKeyValid && roundKeyReady, and key and
//                        index stay stable while valid is high and ready low
//   done                 one-cycle pulse after the last key transfers
//   sBoxRequest          word to substitute (zero when not being looked up)
//   sBoxResponse         S-box of sBoxRequest
//
// Build option KEY_EXPANDER_SBOX_REG_EN: registers the S-box reply in an
// extra SUB state ahead of COMPUTE, cutting the combinational path through
// the S-box at the cost of one extra cycle per key.
module key_expander
    import aes_pkg::*;
#(
    parameter int         NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter logic [7:0] RCON_INIT  = AES_RCON_INIT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] keyIn,
    output logic         ready,
    output logic [127:0] roundKey,
    output logic [3:0]   roundKeyIndex,
    output logic         roundKeyValid,
    input  logic         roundKeyReady,
    output logic         done,
    output logic [31:0]  sBoxRequest,
    input  logic [31:0]  sBoxResponse
);

    ke_state_e    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;

    logic         handshake;
    logic         last_key;
    logic [31:0]  sub_word;
    logic [127:0] next_key;

    assign handshake = roundKeyValid && roundKeyReady;
    assign last_key  = (idx_q == 4'(NUM_ROUNDS));

`ifdef KEY_EXPANDER_SBOX_REG_EN
    logic [31:0] sub_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_q <= '0;
        end else if (state_q == SUB) begin
            sub_q <= sBoxResponse;
        end
    end

    assign sub_word = sub_q;
`else
    assign sub_word = sBoxResponse;
`endif

    key_round_step u_step (
        .prevKey (key_q),
        .subWord (sub_word),
        .rcon    (rcon_q),
        .nextKey (next_key)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= RCON_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (handshake) begin
`ifdef KEY_EXPANDER_SBOX_REG_EN
                    state_d = last_key ? IDLE : SUB;
`else
                    state_d = last_key ? IDLE : COMPUTE;
`endif
                end
            end
            SUB:     state_d = COMPUTE;
            COMPUTE: state_d = EMIT;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        key_d  = key_q;
        idx_d  = idx_q;
        rcon_d = rcon_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d  = keyIn;
                    idx_d  = '0;
                    rcon_d = RCON_INIT;
                end
            end
            EMIT: begin
                done_d = handshake && last_key;
            end
            COMPUTE: begin
                key_d  = next_key;
                idx_d  = idx_q + 4'd1;
                rcon_d = xtime(rcon_q);
            end
            default: ;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        ready         = 1'b0;
        roundKeyValid = 1'b0;
        sBoxRequest   = '0;
        case (state_q)
            IDLE: ready = 1'b1;
            EMIT: roundKeyValid = 1'b1;
`ifdef KEY_EXPANDER_SBOX_REG_EN
            SUB:  sBoxRequest = rot_word(key_q[31:0]);
`else
            COMPUTE: sBoxRequest = rot_word(key_q[31:0]);
`endif
            default: ;
        endcase
    end

    assign roundKey      = key_q;
    assign roundKeyIndex = idx_q;
    assign done          = done_q;

endmodule

// File: tb/tb_key_expander.sv
// Bench for key_expander: bench-side S-box feeds the DUT, an independent
// key-schedule model fills the expected queue at each start, and the key
// stream is checked against the queue head every cycle it is valid.
module tb_key_expander;

`ifdef KEY_EXPANDER_SBOX_REG_EN
    localparam int TOTAL_EDGES = 31;
`else
    localparam int TOTAL_EDGES = 21;
`endif

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_K10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] keyIn;
    logic         ready;
    logic [127:0] roundKey;
    logic [3:0]   roundKeyIndex;
    logic         roundKeyValid;
    logic         roundKeyReady;
    logic         done;
    logic [31:0]  sBoxRequest;
    logic [31:0]  sBoxResponse;

    int checks = 0;
    int errors = 0;

    // {index, key}
    logic [131:0] exp_q[$];

    always #5 clk = ~clk;

    key_expander dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .keyIn         (keyIn),
        .ready         (ready),
        .roundKey      (roundKey),
        .roundKeyIndex (roundKeyIndex),
        .roundKeyValid (roundKeyValid),
        .roundKeyReady (roundKeyReady),
        .done          (done),
        .sBoxRequest   (sBoxRequest),
        .sBoxResponse  (sBoxResponse)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254, then the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sbox_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign sBoxResponse = sbox_word(sBoxRequest);

    task automatic model_push(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [7:0]  rc [0:9];
        logic [31:0] t;
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sbox_word({t[23:0], t[31:24]}) ^ {rc[i/4-1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            exp_q.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
        end
    endtask

    task automatic start_sched(input logic [127:0] key);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready got=%b exp=1", ready);
        end
        keyIn = key;
        start = 1'b1;
        model_push(key);
        @(negedge clk);
        start = 1'b0;
        keyIn = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called at the negedge after the start-accept edge. Follows the stream
    // until key 10 transfers (or a mid-schedule reset is applied). Returns
    // the keys seen at index 1 and 10 and the edge count of the final
    // handshake; on normal completion also checks the done pulse.
    task automatic run_keys(input int bp, input int busy_idx, input int reset_idx,
                            output logic [127:0] k1, output logic [127:0] k10,
                            output int last_edge);
        int           edges;
        int           gap;
        bit           fin;
        bit           busy_done;
        logic [131:0] head;
        logic [127:0] last_key;
        logic [31:0]  exp_req;
        edges = 0; gap = 0; fin = 0; busy_done = 0;
        k1 = '0; k10 = '0; last_edge = -1; last_key = '0;
        while (!fin && edges < 400) begin
            start = 1'b0;
            roundKeyReady = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready got=%b exp=0 edge=%0d", ready, edges);
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL early_done got=%b exp=0 edge=%0d", done, edges);
            end
            if (roundKeyValid === 1'b1) begin
                gap = 0;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_key got idx=%0d exp=none", roundKeyIndex);
                    fin = 1;
                end else begin
                    head = exp_q[0];
                    checks++;
                    if (roundKey !== head[127:0]) begin
                        errors++;
                        $display("FAIL round_key got=%h exp=%h", roundKey, head[127:0]);
                    end
                    checks++;
                    if (roundKeyIndex !== head[131:128]) begin
                        errors++;
                        $display("FAIL key_index got=%0d exp=%0d", roundKeyIndex, head[131:128]);
                    end
                    checks++;
                    if (sBoxRequest !== 32'h0) begin
                        errors++;
                        $display("FAIL sbox_in_emit got=%h exp=0", sBoxRequest);
                    end
                    if (reset_idx >= 0 && int'(head[131:128]) == reset_idx) begin
                        reset = 1'b1;
                        @(negedge clk);
                        reset = 1'b0;
                        checks++;
                        if (ready !== 1'b1 || roundKeyValid !== 1'b0 || done !== 1'b0) begin
                            errors++;
                            $display("FAIL mid_reset_ctl got=%b%b%b exp=100", ready, roundKeyValid, done);
                        end
                        checks++;
                        if (roundKey !== 128'h0 || roundKeyIndex !== 4'h0 || sBoxRequest !== 32'h0) begin
                            errors++;
                            $display("FAIL mid_reset_data got=%h/%0d/%h exp=0/0/0", roundKey, roundKeyIndex, sBoxRequest);
                        end
                        exp_q.delete();
                        last_edge = -2;
                        return;
                    end
                    if (busy_idx >= 0 && int'(head[131:128]) == busy_idx && !busy_done) begin
                        start = 1'b1;
                        keyIn = 128'h0;
                        busy_done = 1;
                    end
                    if (roundKeyReady) begin
                        void'(exp_q.pop_front());
                        last_key = head[127:0];
                        if (head[131:128] == 4'd1) k1 = roundKey;
                        if (head[131:128] == 4'd10) begin
                            k10 = roundKey;
                            last_edge = edges + 1;
                            fin = 1;
                        end
                    end
                end
            end else begin
                gap++;
`ifdef KEY_EXPANDER_SBOX_REG_EN
                exp_req = (gap == 1) ? {last_key[23:0], last_key[31:24]} : 32'h0;
`else
                exp_req = {last_key[23:0], last_key[31:24]};
`endif
                checks++;
                if (sBoxRequest !== exp_req) begin
                    errors++;
                    $display("FAIL sbox_request got=%h exp=%h gap=%0d", sBoxRequest, exp_req, gap);
                end
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        roundKeyReady = 1'b0;
        if (!fin) begin
            errors++;
            $display("FAIL schedule_timeout got=%0d edges exp=done", edges);
            return;
        end
        checks++;
        if (done !== 1'b1 || ready !== 1'b1 || roundKeyValid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got=%b%b%b exp=110 (done,ready,valid)", done, ready, roundKeyValid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; keyIn = '0; roundKeyReady = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || roundKeyValid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b%b%b exp=100", ready, roundKeyValid, done);
        end
        checks++;
        if (roundKey !== 128'h0 || roundKeyIndex !== 4'h0 || sBoxRequest !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got=%h/%0d/%h exp=0/0/0", roundKey, roundKeyIndex, sBoxRequest);
        end
        // start together with reset must be dropped
        start = 1'b1; keyIn = FIPS_KEY;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        checks++;
        if (roundKeyValid !== 1'b0 || ready !== 1'b1 || roundKey !== 128'h0) begin
            errors++;
            $display("FAIL reset_start got=%b%b/%h exp=01/0", roundKeyValid, ready, roundKey);
        end
        @(negedge clk);
        checks++;
        if (roundKeyValid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_start_late got=%b%b exp=01", roundKeyValid, ready);
        end
    endtask

    task automatic test_fips();
        logic [127:0] k1, k10;
        int           le;
        start_sched(FIPS_KEY);
        run_keys(0, -1, -1, k1, k10, le);
        checks++;
        if (k1 !== FIPS_K1) begin
            errors++;
            $display("FAIL fips_k1 got=%h exp=%h", k1, FIPS_K1);
        end
        checks++;
        if (k10 !== FIPS_K10) begin
            errors++;
            $display("FAIL fips_k10 got=%h exp=%h", k10, FIPS_K10);
        end
        checks++;
        if (le !== TOTAL_EDGES) begin
            errors++;
            $display("FAIL fips_cycles got=%0d exp=%0d", le, TOTAL_EDGES);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width got=%b exp=0", done);
        end
    endtask

    task automatic test_zero_key();
        logic [127:0] k1, k10;
        int           le;
        start_sched(128'h0);
        run_keys(0, -1, -1, k1, k10, le);
        checks++;
        if (k1 !== ZERO_K1) begin
            errors++;
            $display("FAIL zero_k1 got=%h exp=%h", k1, ZERO_K1);
        end
        checks++;
        if (k10 !== ZERO_K10) begin
            errors++;
            $display("FAIL zero_k10 got=%h exp=%h", k10, ZERO_K10);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [127:0] k1, k10;
        int           le;
        start_sched(FIPS_KEY);
        run_keys(1, -1, -1, k1, k10, le);
        checks++;
        if (k10 !== FIPS_K10 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_sequence got=%h left=%0d exp=%h left=0", k10, exp_q.size(), FIPS_K10);
        end
        @(negedge clk);
    endtask

    task automatic test_start_busy();
        logic [127:0] k1, k10;
        int           le;
        start_sched(FIPS_KEY);
        run_keys(0, 3, -1, k1, k10, le);
        checks++;
        if (k10 !== FIPS_K10 || le !== TOTAL_EDGES) begin
            errors++;
            $display("FAIL busy_start got=%h/%0d exp=%h/%0d", k10, le, FIPS_K10, TOTAL_EDGES);
        end
        @(negedge clk);
        checks++;
        if (roundKeyValid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_idle got=%b%b exp=01", roundKeyValid, ready);
        end
    endtask

    task automatic test_mid_reset();
        logic [127:0] k1, k10;
        int           le;
        start_sched(FIPS_KEY);
        run_keys(0, -1, 5, k1, k10, le);
        checks++;
        if (le !== -2) begin
            errors++;
            $display("FAIL mid_reset_taken got=%0d exp=-2", le);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (roundKeyValid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet got=%b%b exp=00", roundKeyValid, done);
            end
            @(negedge clk);
        end
        start_sched(128'h0);
        run_keys(0, -1, -1, k1, k10, le);
        checks++;
        if (k1 !== ZERO_K1 || k10 !== ZERO_K10) begin
            errors++;
            $display("FAIL reset_restart got=%h/%h exp=%h/%h", k1, k10, ZERO_K1, ZERO_K10);
        end
        @(negedge clk);
    endtask

    // Second schedule starts in the very cycle done is high.
    task automatic test_back_to_back();
        logic [127:0] k1, k10;
        int           le;
        start_sched(128'h0);
        run_keys(0, -1, -1, k1, k10, le);
        start_sched(FIPS_KEY);
        run_keys(0, -1, -1, k1, k10, le);
        checks++;
        if (k1 !== FIPS_K1 || k10 !== FIPS_K10) begin
            errors++;
            $display("FAIL b2b_keys got=%h/%h exp=%h/%h", k1, k10, FIPS_K1, FIPS_K10);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fips();
        test_zero_key();
        test_backpressure();
        test_start_busy();
        test_mid_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
